// File: rtl/axis_pulse_pkg.sv
// Shared types and constants for the boxcar pulse integrator.
// Holds the FSM state encoding and the bit layout of the status word.
package axis_pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_RAMP_UP = 3'd2,
        ST_PULSE   = 3'd3,
        ST_RAMP_DN = 3'd4,
        ST_POST    = 3'd5,
        ST_EMIT    = 3'd6
    } pulse_state_e;

    // Status word layout: {pulse_count[27:0], reserved, state[2:0]}
    localparam int STS_STATE_LSB = 0;
    localparam int STS_STATE_W   = 3;
    localparam int STS_RSVD_BIT  = 3;
    localparam int STS_CNT_LSB   = 4;
    localparam int STS_CNT_W     = 28;

    // True in the states that consume samples from the input stream.
    function automatic logic is_run_state(input pulse_state_e s);
        return (s == ST_PRE) || (s == ST_RAMP_UP) || (s == ST_PULSE) ||
               (s == ST_RAMP_DN) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/pulse_phase_counter.sv
// Sample counter shared by every phase of the measurement period.
// Raises advance_o on the L-th accepted sample of a phase of length L, or
// immediately when the phase length is zero; the count then restarts at 0.
module pulse_phase_counter
    import axis_pulse_pkg::*;
#(
    parameter int CNTR_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  clear_i,
    input  logic                  active_i,
    input  logic                  accept_i,
    input  logic [CNTR_WIDTH-1:0] len_i,
    output logic                  advance_o,
    output logic                  zero_len_o
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [CNTR_WIDTH-1:0] cnt_d;
    logic                  last_s;

    // Decode the end-of-phase strobe and compute the next count.
    always_comb begin
        zero_len_o = (len_i == CNT_ZERO);
        last_s     = accept_i && (cnt_q == (len_i - CNT_ONE));
        advance_o  = active_i && (zero_len_o || last_s);
        if (clear_i || !active_i) begin
            cnt_d = CNT_ZERO;
        end else if (advance_o) begin
            cnt_d = CNT_ZERO;
        end else if (accept_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sample counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_pulse_integrator.sv
// Boxcar pulse integrator: integrates offset (PRE+POST) and pulse windows of
// an AXI-Stream sample stream, averages 2^N periods of (pulse - offset) and
// emits the mean on an AXI-Stream result port with an overload flag.
// Optional macro AXIS_PULSE_INTEGRATOR_STICKY_EN makes the overload flag
// sticky until ovl_clear.
module axis_pulse_integrator
    import axis_pulse_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = 32,
    parameter int AVG_LOG2_MAX     = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_enable,
    input  logic [CNTR_WIDTH-1:0]       cfg_offset_len,
    input  logic [CNTR_WIDTH-1:0]       cfg_ramp_len,
    input  logic [CNTR_WIDTH-1:0]       cfg_width_len,
    input  logic [3:0]                  cfg_avg_log2,
    input  logic [ACC_WIDTH-1:0]        cfg_threshold,
    input  logic                        ovl_clear,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [ACC_WIDTH-1:0]        m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        overload,
    output logic [31:0]                 sts_data
);

    localparam int PCNT_W = AVG_LOG2_MAX + 1;
    localparam logic [PCNT_W-1:0]     PCNT_ZERO = {PCNT_W{1'b0}};
    localparam logic [PCNT_W-1:0]     PCNT_ONE  = {{(PCNT_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0]  ACC_ZERO  = {ACC_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] LEN_ZERO  = {CNTR_WIDTH{1'b0}};
    localparam logic [STS_CNT_W-1:0]  PC_ONE    = {{(STS_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]            AVG_MAX_4 = 4'(AVG_LOG2_MAX);

    pulse_state_e state_q, state_d;

    // Configuration latched at period-group start
    logic [CNTR_WIDTH-1:0] off_len_q, ramp_len_q, width_len_q;
    logic [3:0]            n_q;
    logic [ACC_WIDTH-1:0]  thr_q;

    logic [ACC_WIDTH-1:0]  offset_acc_q, offset_acc_d;
    logic [ACC_WIDTH-1:0]  pulse_acc_q, pulse_acc_d;
    logic [ACC_WIDTH-1:0]  avg_acc_q, avg_acc_d;
    logic [PCNT_W-1:0]     period_cnt_q, period_cnt_d;
    logic [STS_CNT_W-1:0]  pulse_count_q, pulse_count_d;
    logic [ACC_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  overload_q, overload_d;

    logic [CNTR_WIDTH-1:0] phase_len_s;
    logic                  phase_active_s;
    logic                  phase_advance_s;
    logic                  zero_len_s;
    logic                  accept_s;
    logic                  latch_cfg_s;
    logic                  abort_s;
    logic                  period_end_s;
    logic                  emit_s;
    logic                  last_period_s;
    logic [3:0]            n_clamp_s;
    logic [PCNT_W-1:0]     period_last_s;
    logic [ACC_WIDTH-1:0]  sample_ext_s;
    logic [ACC_WIDTH-1:0]  offset_sum_s;
    logic [ACC_WIDTH-1:0]  diff_s;
    logic [ACC_WIDTH-1:0]  avg_sum_s;
    logic [ACC_WIDTH-1:0]  result_s;
    logic                  compare_s;

`ifndef AXIS_PULSE_INTEGRATOR_STICKY_EN
    logic unused_ovl_clear_s;
    assign unused_ovl_clear_s = ovl_clear;
`endif

    // Select the length of the phase currently being counted.
    always_comb begin
        phase_len_s    = LEN_ZERO;
        phase_active_s = 1'b1;
        case (state_q)
            ST_PRE, ST_POST:        phase_len_s = off_len_q;
            ST_RAMP_UP, ST_RAMP_DN: phase_len_s = ramp_len_q;
            ST_PULSE:               phase_len_s = width_len_q;
            default:                phase_active_s = 1'b0;
        endcase
    end

    // A zero-length phase holds tready low for its single cycle.
    assign s_axis_tready = is_run_state(state_q) && !zero_len_s;
    assign accept_s      = s_axis_tvalid && s_axis_tready;

    pulse_phase_counter #(
        .CNTR_WIDTH (CNTR_WIDTH)
    ) u_phase_cnt (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .clear_i    (abort_s),
        .active_i   (phase_active_s),
        .accept_i   (accept_s),
        .len_i      (phase_len_s),
        .advance_o  (phase_advance_s),
        .zero_len_o (zero_len_s)
    );

    assign n_clamp_s     = (cfg_avg_log2 > AVG_MAX_4) ? AVG_MAX_4 : cfg_avg_log2;
    assign period_last_s = (PCNT_ONE << n_q) - PCNT_ONE;
    assign last_period_s = (period_cnt_q == period_last_s);

    // FSM next state; the enable check precedes phase advance so an abort wins.
    always_comb begin
        state_d      = state_q;
        latch_cfg_s  = 1'b0;
        abort_s      = 1'b0;
        period_end_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d     = ST_PRE;
                    latch_cfg_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE, ST_RAMP_UP, ST_PULSE, ST_RAMP_DN, ST_POST: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                    abort_s = 1'b1;
                end else if (phase_advance_s) begin
                    case (state_q)
                        ST_PRE:     state_d = ST_RAMP_UP;
                        ST_RAMP_UP: state_d = ST_PULSE;
                        ST_PULSE:   state_d = ST_RAMP_DN;
                        ST_RAMP_DN: state_d = ST_POST;
                        default: begin
                            period_end_s = 1'b1;
                            state_d      = last_period_s ? ST_EMIT : ST_PRE;
                        end
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_EMIT: begin
                if (m_axis_tready && cfg_enable) begin
                    state_d     = ST_PRE;
                    latch_cfg_s = 1'b1;
                end else if (m_axis_tready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // End-of-period arithmetic, including the sample accepted on the closing edge.
    always_comb begin
        sample_ext_s = {{(ACC_WIDTH-AXIS_TDATA_WIDTH){s_axis_tdata[AXIS_TDATA_WIDTH-1]}},
                        s_axis_tdata};
        if (accept_s && ((state_q == ST_PRE) || (state_q == ST_POST))) begin
            offset_sum_s = offset_acc_q + sample_ext_s;
        end else begin
            offset_sum_s = offset_acc_q;
        end
        diff_s    = pulse_acc_q - offset_sum_s;
        avg_sum_s = avg_acc_q + diff_s;
        result_s  = $signed(avg_sum_s) >>> n_q;
        compare_s = ($signed(result_s) < $signed(thr_q));
        emit_s    = period_end_s && last_period_s;
    end

    // Accumulator, period counter and result-register next state.
    always_comb begin
        offset_acc_d  = offset_acc_q;
        pulse_acc_d   = pulse_acc_q;
        avg_acc_d     = avg_acc_q;
        period_cnt_d  = period_cnt_q;
        pulse_count_d = pulse_count_q;
        m_tdata_d     = m_tdata_q;
        m_tvalid_d    = m_tvalid_q;
        if (abort_s) begin
            offset_acc_d = ACC_ZERO;
            pulse_acc_d  = ACC_ZERO;
            avg_acc_d    = ACC_ZERO;
            period_cnt_d = PCNT_ZERO;
        end else if (period_end_s) begin
            offset_acc_d  = ACC_ZERO;
            pulse_acc_d   = ACC_ZERO;
            pulse_count_d = pulse_count_q + PC_ONE;
            if (last_period_s) begin
                avg_acc_d    = ACC_ZERO;
                period_cnt_d = PCNT_ZERO;
                m_tdata_d    = result_s;
                m_tvalid_d   = 1'b1;
            end else begin
                avg_acc_d    = avg_sum_s;
                period_cnt_d = period_cnt_q + PCNT_ONE;
            end
        end else if (accept_s && (state_q == ST_PULSE)) begin
            pulse_acc_d = pulse_acc_q + sample_ext_s;
        end else if (accept_s) begin
            offset_acc_d = offset_sum_s;
        end else begin
            offset_acc_d = offset_acc_q;
        end
        if ((state_q == ST_EMIT) && m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_d;
        end
    end

    // Overload flag next state (level or sticky).
    always_comb begin
        overload_d = overload_q;
`ifdef AXIS_PULSE_INTEGRATOR_STICKY_EN
        if (emit_s && compare_s) begin
            overload_d = 1'b1;
        end else if (ovl_clear) begin
            overload_d = 1'b0;
        end else begin
            overload_d = overload_q;
        end
`else
        if (emit_s) begin
            overload_d = compare_s;
        end else begin
            overload_d = overload_q;
        end
`endif
    end

    // State, datapath and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            off_len_q     <= LEN_ZERO;
            ramp_len_q    <= LEN_ZERO;
            width_len_q   <= LEN_ZERO;
            n_q           <= 4'd0;
            thr_q         <= ACC_ZERO;
            offset_acc_q  <= ACC_ZERO;
            pulse_acc_q   <= ACC_ZERO;
            avg_acc_q     <= ACC_ZERO;
            period_cnt_q  <= PCNT_ZERO;
            pulse_count_q <= {STS_CNT_W{1'b0}};
            m_tdata_q     <= ACC_ZERO;
            m_tvalid_q    <= 1'b0;
            overload_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            offset_acc_q  <= offset_acc_d;
            pulse_acc_q   <= pulse_acc_d;
            avg_acc_q     <= avg_acc_d;
            period_cnt_q  <= period_cnt_d;
            pulse_count_q <= pulse_count_d;
            m_tdata_q     <= m_tdata_d;
            m_tvalid_q    <= m_tvalid_d;
            overload_q    <= overload_d;
            if (latch_cfg_s) begin
                off_len_q   <= cfg_offset_len;
                ramp_len_q  <= cfg_ramp_len;
                width_len_q <= cfg_width_len;
                n_q         <= n_clamp_s;
                thr_q       <= cfg_threshold;
            end else begin
                off_len_q   <= off_len_q;
                ramp_len_q  <= ramp_len_q;
                width_len_q <= width_len_q;
                n_q         <= n_q;
                thr_q       <= thr_q;
            end
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tvalid_q;
    assign overload      = overload_q;

    // Pack the status word from registered state.
    always_comb begin
        sts_data = 32'h0000_0000;
        sts_data[STS_STATE_LSB +: STS_STATE_W] = state_q;
        sts_data[STS_RSVD_BIT]                 = 1'b0;
        sts_data[STS_CNT_LSB +: STS_CNT_W]     = pulse_count_q;
    end

endmodule

// File: tb/tb_axis_pulse_integrator.sv
// Directed self-checking bench for axis_pulse_integrator.
module tb_axis_pulse_integrator;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cfg_enable;
    logic [15:0] cfg_offset_len, cfg_ramp_len, cfg_width_len;
    logic [3:0]  cfg_avg_log2;
    logic [31:0] cfg_threshold;
    logic        ovl_clear;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        overload;
    logic [31:0] sts_data;

    int checks = 0;
    int failures = 0;
    int off_len, ramp_len, wid_len;

    axis_pulse_integrator dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_enable     (cfg_enable),
        .cfg_offset_len (cfg_offset_len),
        .cfg_ramp_len   (cfg_ramp_len),
        .cfg_width_len  (cfg_width_len),
        .cfg_avg_log2   (cfg_avg_log2),
        .cfg_threshold  (cfg_threshold),
        .ovl_clear      (ovl_clear),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .overload       (overload),
        .sts_data       (sts_data)
    );

    always #5 aclk = ~aclk;

    task automatic do_reset();
        aresetn = 1'b0; cfg_enable = 1'b0; ovl_clear = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 16'd0; m_axis_tready = 1'b0;
        cfg_offset_len = 16'd0; cfg_ramp_len = 16'd0; cfg_width_len = 16'd0;
        cfg_avg_log2 = 4'd0; cfg_threshold = 32'd0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic start(input int off, input int ramp, input int wid, input int n, input int thr);
        off_len = off; ramp_len = ramp; wid_len = wid;
        cfg_offset_len = 16'(off); cfg_ramp_len = 16'(ramp); cfg_width_len = 16'(wid);
        cfg_avg_log2 = 4'(n); cfg_threshold = 32'(thr);
        cfg_enable = 1'b1;
        @(negedge aclk);
    endtask

    // Present one sample and step past the edge that accepts it (bounded).
    task automatic send(input int v);
        bit done = 1'b0;
        s_axis_tdata  = 16'(v);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (s_axis_tready) done = 1'b1;
            @(negedge aclk);
        end
        checks++;
        if (!done) begin failures++; $display("FAIL send_timeout got=no_tready exp=tready sample=%0d", v); end
    endtask

    task automatic run_period(input int pre_v, input int ramp_v, input int first_v, input int pulse_v, input int post_v);
        for (int i = 0; i < off_len; i++) send(pre_v);
        for (int i = 0; i < ramp_len; i++) send(ramp_v);
        for (int i = 0; i < wid_len; i++) send((i == 0) ? first_v : pulse_v);
        for (int i = 0; i < ramp_len; i++) send(ramp_v);
        for (int i = 0; i < off_len; i++) send(post_v);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_emit();
        for (int i = 0; i < 32 && !m_axis_tvalid; i++) @(negedge aclk);
        checks++;
        if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL emit_timeout got=%b exp=1", m_axis_tvalid); end
    endtask

    task automatic ack_emit();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready got=%b exp=0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid got=%b exp=0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_m_tlast got=%b exp=0", m_axis_tlast); end
        if (m_axis_tdata !== 32'd0) begin failures++; $display("FAIL rst_m_tdata got=%0d exp=0", m_axis_tdata); end
        if (overload !== 1'b0) begin failures++; $display("FAIL rst_overload got=%b exp=0", overload); end
        if (sts_data !== 32'd0) begin failures++; $display("FAIL rst_sts got=%h exp=0", sts_data); end
        cfg_offset_len = 16'd4; cfg_ramp_len = 16'd2; cfg_width_len = 16'd8;
        cfg_enable = 1'b1;
        @(negedge aclk);
        checks += 2;
        if (sts_data !== 32'd1) begin failures++; $display("FAIL idle_to_pre_sts got=%h exp=1", sts_data); end
        if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL pre_s_tready got=%b exp=1", s_axis_tready); end
    endtask

    task automatic test_basic();
        do_reset();
        start(4, 2, 8, 0, 0);
        run_period(10, 999, 100, 100, 10);
        checks += 6;
        if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b exp=1", m_axis_tvalid); end
        if (m_axis_tdata !== 32'd720) begin failures++; $display("FAIL basic_tdata got=%0d exp=720", $signed(m_axis_tdata)); end
        if (m_axis_tlast !== 1'b1) begin failures++; $display("FAIL basic_tlast got=%b exp=1", m_axis_tlast); end
        if (overload !== 1'b0) begin failures++; $display("FAIL basic_overload got=%b exp=0", overload); end
        if (sts_data !== 32'h16) begin failures++; $display("FAIL basic_sts got=%h exp=16", sts_data); end
        if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL basic_emit_tready got=%b exp=0", s_axis_tready); end
        ack_emit();
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL basic_tvalid_drop got=%b exp=0", m_axis_tvalid); end
        if (sts_data[2:0] !== 3'd1) begin failures++; $display("FAIL basic_back_to_pre got=%0d exp=1", sts_data[2:0]); end
    endtask

    task automatic test_average();
        do_reset();
        start(4, 2, 8, 2, 0);
        run_period(10, 999, 26, 22, 10);
        run_period(10, 999, 35, 35, 10);
        run_period(10, 999, 51, 47, 10);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL avg_early_emit got=%b exp=0", m_axis_tvalid); end
        run_period(10, 999, 64, 60, 10);
        checks += 3;
        if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL avg_tvalid got=%b exp=1", m_axis_tvalid); end
        if (m_axis_tdata !== 32'd251) begin failures++; $display("FAIL avg_tdata got=%0d exp=251", $signed(m_axis_tdata)); end
        if (sts_data !== 32'd70) begin failures++; $display("FAIL avg_sts got=%h exp=46", sts_data); end
        ack_emit();
    endtask

    task automatic test_backpressure();
        do_reset();
        start(4, 2, 8, 0, 0);
        run_period(10, 999, 100, 100, 10);
        s_axis_tdata = 16'd777; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            checks += 3;
            if (m_axis_tdata !== 32'd720) begin failures++; $display("FAIL bp_tdata cyc=%0d got=%0d exp=720", i, m_axis_tdata); end
            if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL bp_tvalid cyc=%0d got=%b exp=1", i, m_axis_tvalid); end
            if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL bp_s_tready cyc=%0d got=%b exp=0", i, s_axis_tready); end
        end
        ack_emit();
        run_period(1, 999, 3, 3, 1);
        checks++;
        if (m_axis_tdata !== 32'd16) begin failures++; $display("FAIL bp_next_tdata got=%0d exp=16", $signed(m_axis_tdata)); end
        ack_emit();
    endtask

    task automatic test_zero_ramp();
        do_reset();
        start(3, 0, 5, 1, 0);
        run_period(2, 999, 10, 10, 4);
        run_period(-1, 999, 20, 7, -1);
        wait_emit();
        checks++;
        if (m_axis_tdata !== 32'd43) begin failures++; $display("FAIL zr_tdata got=%0d exp=43", $signed(m_axis_tdata)); end
        ack_emit();
    endtask

    task automatic test_overload();
        do_reset();
        start(4, 2, 8, 0, 0);
        run_period(10, 999, -50, -50, 10);
        checks += 2;
        if (m_axis_tdata !== 32'hFFFF_FE20) begin failures++; $display("FAIL ovl_neg_tdata got=%0d exp=-480", $signed(m_axis_tdata)); end
        if (overload !== 1'b1) begin failures++; $display("FAIL ovl_set got=%b exp=1", overload); end
        ack_emit();
        ovl_clear = 1'b1; @(negedge aclk); ovl_clear = 1'b0; @(negedge aclk);
        checks++;
`ifdef AXIS_PULSE_INTEGRATOR_STICKY_EN
        if (overload !== 1'b0) begin failures++; $display("FAIL ovl_clear_sticky got=%b exp=0", overload); end
`else
        if (overload !== 1'b1) begin failures++; $display("FAIL ovl_clear_ignored got=%b exp=1", overload); end
`endif
        ovl_clear = 1'b1;
        run_period(10, 999, -50, -50, 10);
        checks++;
        if (overload !== 1'b1) begin failures++; $display("FAIL ovl_set_beats_clear got=%b exp=1", overload); end
        ovl_clear = 1'b0;
        ack_emit();
        run_period(10, 999, 100, 100, 10);
        checks++;
`ifdef AXIS_PULSE_INTEGRATOR_STICKY_EN
        if (overload !== 1'b1) begin failures++; $display("FAIL ovl_sticky_hold got=%b exp=1", overload); end
`else
        if (overload !== 1'b0) begin failures++; $display("FAIL ovl_follow_drop got=%b exp=0", overload); end
`endif
        ack_emit();
        ovl_clear = 1'b1; @(negedge aclk); ovl_clear = 1'b0; @(negedge aclk);
        checks++;
        if (overload !== 1'b0) begin failures++; $display("FAIL ovl_final got=%b exp=0", overload); end
    endtask

    task automatic test_neg_avg();
        do_reset();
        start(1, 0, 1, 1, -3);
        run_period(0, 999, -3, -3, 0);
        run_period(1, 999, -2, -2, 1);
        wait_emit();
        checks += 2;
        if (m_axis_tdata !== 32'hFFFF_FFFC) begin failures++; $display("FAIL neg_avg_tdata got=%0d exp=-4", $signed(m_axis_tdata)); end
        if (overload !== 1'b1) begin failures++; $display("FAIL neg_avg_overload got=%b exp=1", overload); end
        ack_emit();
    endtask

    task automatic test_clamp();
        do_reset();
        start(0, 0, 1, 15, 0);
        for (int p = 0; p < 256; p++) run_period(0, 999, 5, 5, 0);
        wait_emit();
        checks += 2;
        if (m_axis_tdata !== 32'd5) begin failures++; $display("FAIL clamp_tdata got=%0d exp=5", $signed(m_axis_tdata)); end
        if (sts_data !== 32'd4102) begin failures++; $display("FAIL clamp_sts got=%h exp=1006", sts_data); end
        ack_emit();
    endtask

    task automatic test_abort();
        do_reset();
        start(4, 2, 8, 0, 0);
        run_period(10, 999, -50, -50, 10);
        ack_emit();
        for (int i = 0; i < 4; i++) send(10);
        for (int i = 0; i < 2; i++) send(999);
        for (int i = 0; i < 3; i++) send(100);
        #2 aresetn = 1'b0;
        #1;
        checks += 5;
        if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL abort_rst_s_tready got=%b exp=0", s_axis_tready); end
        if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL abort_rst_tvalid got=%b exp=0", m_axis_tvalid); end
        if (m_axis_tdata !== 32'd0) begin failures++; $display("FAIL abort_rst_tdata got=%0d exp=0", m_axis_tdata); end
        if (overload !== 1'b0) begin failures++; $display("FAIL abort_rst_overload got=%b exp=0", overload); end
        if (sts_data !== 32'd0) begin failures++; $display("FAIL abort_rst_sts got=%h exp=0", sts_data); end
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        send(50);
        send(50);
        cfg_enable = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge aclk);
        checks += 2;
        if (sts_data !== 32'd0) begin failures++; $display("FAIL abort_en_sts got=%h exp=0", sts_data); end
        if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL abort_en_s_tready got=%b exp=0", s_axis_tready); end
        cfg_enable = 1'b1;
        @(negedge aclk);
        run_period(10, 999, 100, 100, 10);
        checks += 3;
        if (m_axis_tdata !== 32'd720) begin failures++; $display("FAIL abort_clean_tdata got=%0d exp=720", $signed(m_axis_tdata)); end
        if (overload !== 1'b0) begin failures++; $display("FAIL abort_clean_overload got=%b exp=0", overload); end
        if (sts_data !== 32'h16) begin failures++; $display("FAIL abort_clean_sts got=%h exp=16", sts_data); end
        ack_emit();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_average();
        test_backpressure();
        test_zero_ramp();
        test_overload();
        test_neg_avg();
        test_clamp();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
